dmem_load_unit: RTL

Read-side companion to the store byte-enable logic in the MEM stage of the pipelined core. Accepts one load (lw/lh/lhu/lb/lbu) at a time and issues word-aligned reads to data memory over a valid/ready request channel. It merges one or two response words, extracts and sign- or zero-extends the addressed bytes, and returns the result to the pipeline. It stalls the pipeline while the load is outstanding. Misaligned halfword and word loads that cross a word boundary are split into two word reads.

---
 rtl/dmem_load_unit.sv | 109 ++++++++++
 1 files changed

// File: rtl/dmem_load_unit.sv
// rtl/dmem_load_unit.sv - MEM-stage load unit: word-aligned reads, split merge, byte/half extraction.
module dmem_load_unit #(
  parameter int XLEN      = 32,
  parameter int ADDR_SIZE = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  input  logic [ADDR_SIZE-1:0] req_addr,
  input  logic [1:0]           req_lwhb,
  input  logic                 req_unsigned,
  output logic                 stall,
  output logic                 mem_rd_valid,
  output logic [ADDR_SIZE-1:0] mem_rd_addr,
  input  logic                 mem_rd_ready,
  input  logic                 mem_rsp_valid,
  input  logic [XLEN-1:0]      mem_rsp_data,
  output logic                 ld_valid,
  output logic [XLEN-1:0]      ld_data,
  output logic                 ld_split
);

  typedef enum logic [2:0] {IDLE, RD0, WT0, RD1, WT1, DONE} state_t;

  state_t               state;
  logic [ADDR_SIZE-1:0] addr_q;
  logic [1:0]           size_q;
  logic                 uns_q;
  logic                 split_q;
  logic [XLEN-1:0]      lo_q;
  logic [XLEN-1:0]      lo_w;
  logic [XLEN-1:0]      hi_w;
  logic [XLEN-1:0]      shifted;
  logic [XLEN-1:0]      ext;

  // A load crosses the word boundary when off + nbytes > 4.
  function automatic logic calc_split(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'b10:   return off == 2'd3;
      2'b11:   return 1'b0;
      default: return off != 2'd0;
    endcase
  endfunction

  // Result is built from the word arriving this cycle, so it can be registered on the DONE edge.
  always_comb begin
    lo_w    = (state == WT1) ? lo_q : mem_rsp_data;
    hi_w    = (state == WT1) ? mem_rsp_data : '0;
    shifted = XLEN'({hi_w, lo_w} >> {addr_q[1:0], 3'b000});
    case (size_q)
      2'b10:   ext = {{(XLEN-16){~uns_q & shifted[15]}}, shifted[15:0]};
      2'b11:   ext = {{(XLEN-8){~uns_q & shifted[7]}}, shifted[7:0]};
      default: ext = shifted;
    endcase
  end

  assign mem_rd_valid = (state == RD0) || (state == RD1);
  assign ld_valid     = (state == DONE);
  assign stall        = ~reset & (((state == IDLE) & req_valid) |
                                  (state == RD0) | (state == WT0) |
                                  (state == RD1) | (state == WT1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      addr_q      <= '0;
      size_q      <= '0;
      uns_q       <= 1'b0;
      split_q     <= 1'b0;
      lo_q        <= '0;
      mem_rd_addr <= '0;
      ld_data     <= '0;
      ld_split    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          addr_q      <= req_addr;
          size_q      <= req_lwhb;
          uns_q       <= req_unsigned;
          split_q     <= calc_split(req_lwhb, req_addr[1:0]);
          mem_rd_addr <= {req_addr[ADDR_SIZE-1:2], 2'b00};
          state       <= RD0;
        end
        RD0: if (mem_rd_ready) state <= WT0;
        WT0: if (mem_rsp_valid) begin
          lo_q <= mem_rsp_data;
          if (split_q) begin
            // Natural wrap of the address register handles the top-of-memory case.
            mem_rd_addr <= mem_rd_addr + ADDR_SIZE'(4);
            state       <= RD1;
          end else begin
            ld_data  <= ext;
            ld_split <= 1'b0;
            state    <= DONE;
          end
        end
        RD1: if (mem_rd_ready) state <= WT1;
        WT1: if (mem_rsp_valid) begin
          ld_data  <= ext;
          ld_split <= 1'b1;
          state    <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
